// File: rtl/csr_exu.sv
// csr_exu: Zicsr read-modify-write sequencer between decode and the machine-mode CSR file.
module csr_exu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [2:0]      funct3,
  input  logic [11:0]     inst_csr_idx,
  input  logic [4:0]      rs1_idx,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      rd_idx,
  output logic            csr_rd_ena,
  output logic            csr_wr_ena,
  output logic [11:0]     csr_idx,
  output logic [XLEN-1:0] csr_wr_data,
  input  logic [XLEN-1:0] csr_rd_data,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic            wb_rd_ena,
  output logic [4:0]      wb_rd_idx,
  output logic [XLEN-1:0] wb_rd_data,
  output logic            wb_illegal
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, state_nxt;
  logic [2:0] f3;
  logic [11:0] idx;
  logic [4:0] rs1, rd;
  logic [XLEN-1:0] src, old_val;
  logic op_rw, op_rs, op_rc, do_write, do_read, illegal;
  assign op_rw = f3[1:0] == 2'b01;
  assign op_rs = f3[1:0] == 2'b10;
  assign op_rc = f3[1:0] == 2'b11;
  assign do_write = op_rw | ((op_rs | op_rc) & (rs1 != 5'd0));
  assign do_read = ~(op_rw & (rd == 5'd0));
  // Writes into the read-only CSR quadrant (addr[11:10]==11) trap.
  assign illegal = (f3[1:0] == 2'b00) | (do_write & (idx[11:10] == 2'b11));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3 <= '0;
      idx <= '0;
      rs1 <= '0;
      rd <= '0;
      src <= '0;
      old_val <= '0;
    end else begin
      if (state == IDLE && inst_valid) begin
        f3 <= funct3;
        idx <= inst_csr_idx;
        rs1 <= rs1_idx;
        rd <= rd_idx;
        src <= funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_data;
      end
      if (state == READ) old_val <= csr_rd_ena ? csr_rd_data : '0;
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = inst_valid ? READ : IDLE;
      READ:  state_nxt = WRITE;
      WRITE: state_nxt = RESP;
      RESP:  state_nxt = wb_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    inst_ready = (state == IDLE) & ~rst;
    csr_rd_ena = (state == READ) & do_read & ~illegal;
    csr_wr_ena = (state == WRITE) & do_write & ~illegal;
    csr_idx = (state == READ || state == WRITE) ? idx : '0;
    csr_wr_data = (state != WRITE) ? '0 : op_rs ? (old_val | src) : op_rc ? (old_val & ~src) : src;
    wb_valid = state == RESP;
    wb_rd_ena = (state == RESP) & ~illegal & (rd != 5'd0);
    wb_rd_idx = (state == RESP) ? rd : '0;
    wb_rd_data = (state == RESP) ? old_val : '0;
    wb_illegal = (state == RESP) & illegal;
  end
endmodule

// File: tb/tb_csr_exu.sv
// tb_csr_exu: directed checks of csr_exu against a small behavioural CSR file.
module tb_csr_exu;
  localparam logic [63:0] MISA = 64'h8000000000000100;
  logic clk = 0, rst = 1;
  logic inst_valid = 0, inst_ready;
  logic [2:0] funct3 = 0;
  logic [11:0] inst_csr_idx = 0, csr_idx;
  logic [4:0] rs1_idx = 0, rd_idx = 0, wb_rd_idx;
  logic [63:0] rs1_data = 0, csr_wr_data, csr_rd_data, wb_rd_data;
  logic csr_rd_ena, csr_wr_ena, wb_valid, wb_ready = 1, wb_rd_ena, wb_illegal;
  logic [63:0] mcycle = 0, mscratch = 0;
  int wr_count = 0;
  logic both_high = 0;
  int checks = 0, errors = 0;
  logic i_ready, r_rd_ena, r_wr_ena, r_wb_valid, w_rd_ena, w_wr_ena, w_wb_valid;
  logic [11:0] r_idx, w_idx;
  logic [63:0] r_mcycle, w_data, snap_ms;
  int wc;
  csr_exu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .funct3(funct3), .inst_csr_idx(inst_csr_idx), .rs1_idx(rs1_idx), .rs1_data(rs1_data),
    .rd_idx(rd_idx), .csr_rd_ena(csr_rd_ena), .csr_wr_ena(csr_wr_ena), .csr_idx(csr_idx),
    .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_rd_ena(wb_rd_ena), .wb_rd_idx(wb_rd_idx),
    .wb_rd_data(wb_rd_data), .wb_illegal(wb_illegal)
  );
  always #5 clk = ~clk;
  always_comb
    csr_rd_data = !csr_rd_ena ? 64'h0 : csr_idx == 12'h301 ? MISA :
                  csr_idx == 12'hB00 ? mcycle : csr_idx == 12'h340 ? mscratch : 64'h0;
  always @(posedge clk) begin
    mcycle <= (csr_wr_ena && csr_idx == 12'hB00) ? csr_wr_data : mcycle + 64'd1;
    if (csr_wr_ena && csr_idx == 12'h340) mscratch <= csr_wr_data;
    if (csr_wr_ena) wr_count <= wr_count + 1;
    if (csr_rd_ena && csr_wr_ena) both_high <= 1'b1;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic set_inst(input logic [2:0] f, input logic [11:0] c, input logic [4:0] r1,
                          input logic [63:0] d, input logic [4:0] rd);
    funct3 = f; inst_csr_idx = c; rs1_idx = r1; rs1_data = d; rd_idx = rd;
  endtask
  task automatic issue(input logic [2:0] f, input logic [11:0] c, input logic [4:0] r1,
                       input logic [63:0] d, input logic [4:0] rd);
    set_inst(f, c, r1, d, rd);
    inst_valid = 1;
    i_ready = inst_ready;
    @(posedge clk); #1;
    inst_valid = 0;
    r_rd_ena = csr_rd_ena; r_wr_ena = csr_wr_ena; r_idx = csr_idx;
    r_mcycle = mcycle; r_wb_valid = wb_valid;
    @(posedge clk); #1;
    w_rd_ena = csr_rd_ena; w_wr_ena = csr_wr_ena; w_idx = csr_idx;
    w_data = csr_wr_data; w_wb_valid = wb_valid;
    @(posedge clk); #1;
  endtask
  task automatic retire();
    @(posedge clk); #1;
    check("retire_valid", wb_valid, 0);
    check("retire_ready", inst_ready, 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", inst_ready, 0);
    check("rst_valid", wb_valid, 0);
    check("rst_idx", csr_idx, 0);
    rst = 0;
    #1;
    check("post_rst_ready", inst_ready, 1);
    issue(3'b010, 12'h301, 5'd0, 64'hDEAD, 5'd5);
    check("misa_accept", i_ready, 1);
    check("misa_rd_ena", r_rd_ena, 1);
    check("misa_rd_idx", r_idx, 12'h301);
    check("misa_rd_nowr", r_wr_ena, 0);
    check("misa_early_valid", r_wb_valid | w_wb_valid, 0);
    check("misa_no_write", w_wr_ena, 0);
    check("misa_wb_valid", wb_valid, 1);
    check("misa_wb_idx", wb_rd_idx, 5);
    check("misa_wb_data", wb_rd_data, MISA);
    check("misa_illegal", wb_illegal, 0);
    check("misa_rd_wb", wb_rd_ena, 1);
    retire();
    issue(3'b001, 12'hB00, 5'd1, 64'h100, 5'd0);
    check("mcw_no_read", r_rd_ena, 0);
    check("mcw_wr_ena", w_wr_ena, 1);
    check("mcw_wr_rd_ena", w_rd_ena, 0);
    check("mcw_wr_idx", w_idx, 12'hB00);
    check("mcw_wr_data", w_data, 64'h100);
    check("mcw_rd_wb", wb_rd_ena, 0);
    check("mcw_wb_data", wb_rd_data, 0);
    retire();
    issue(3'b010, 12'hB00, 5'd0, 64'h0, 5'd1);
    check("mc_after_write", wb_rd_data >= 64'h101 && wb_rd_data < 64'h110, 1);
    check("mc_read_val", wb_rd_data, r_mcycle);
    retire();
    issue(3'b110, 12'hB00, 5'd5, 64'hFFFF, 5'd1);
    check("rsi_wr_ena", w_wr_ena, 1);
    check("rsi_wr_data", w_data, r_mcycle | 64'h5);
    check("rsi_old", wb_rd_data, r_mcycle);
    retire();
    issue(3'b111, 12'hB00, 5'd5, 64'hFFFF, 5'd1);
    check("rci_wr_data", w_data, r_mcycle & ~64'h5);
    check("rci_old", wb_rd_data, r_mcycle);
    retire();
    issue(3'b001, 12'h340, 5'd2, 64'hF0F0F0F0F0F0F0F0, 5'd2);
    retire();
    check("ms_rw", mscratch, 64'hF0F0F0F0F0F0F0F0);
    issue(3'b010, 12'h340, 5'd7, 64'h0F, 5'd2);
    check("ms_rs_old", wb_rd_data, 64'hF0F0F0F0F0F0F0F0);
    check("ms_rs_new", w_data, 64'hF0F0F0F0F0F0F0FF);
    retire();
    issue(3'b011, 12'h340, 5'd7, 64'hF0, 5'd2);
    check("ms_rc_old", wb_rd_data, 64'hF0F0F0F0F0F0F0FF);
    check("ms_rc_new", w_data, 64'hF0F0F0F0F0F0F00F);
    retire();
    issue(3'b101, 12'h340, 5'h1F, 64'hAAAA, 5'd0);
    check("rwi_no_read", r_rd_ena, 0);
    check("rwi_wr_data", w_data, 64'h1F);
    retire();
    check("rwi_ms", mscratch, 64'h1F);
    wc = wr_count;
    issue(3'b001, 12'hF14, 5'd3, 64'h55, 5'd3);
    check("hart_rd_ena", r_rd_ena, 0);
    check("hart_wr_ena", w_wr_ena, 0);
    check("hart_valid", wb_valid, 1);
    check("hart_illegal", wb_illegal, 1);
    check("hart_rd_wb", wb_rd_ena, 0);
    retire();
    issue(3'b100, 12'h340, 5'd0, 64'h0, 5'd3);
    check("f100_rd_ena", r_rd_ena, 0);
    check("f100_illegal", wb_illegal, 1);
    check("f100_rd_wb", wb_rd_ena, 0);
    retire();
    check("illegal_no_wr", wr_count, wc);
    issue(3'b010, 12'hF14, 5'd0, 64'h0, 5'd3);
    check("hart_ro_legal", wb_illegal, 0);
    check("hart_ro_rd_ena", r_rd_ena, 1);
    check("hart_ro_wb", wb_rd_ena, 1);
    retire();
    issue(3'b010, 12'h301, 5'd0, 64'h0, 5'd6);
    wb_ready = 0;
    set_inst(3'b001, 12'h340, 5'd9, 64'h77, 5'd9);
    inst_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", wb_valid, 1);
      check("stall_idx", wb_rd_idx, 6);
      check("stall_data", wb_rd_data, MISA);
      check("stall_ready", inst_ready, 0);
    end
    wb_ready = 1;
    @(posedge clk); #1;
    check("release_valid", wb_valid, 0);
    check("release_ready", inst_ready, 1);
    @(posedge clk); #1;
    inst_valid = 0;
    check("next_rd_ena", csr_rd_ena, 1);
    check("next_idx", csr_idx, 12'h340);
    repeat (2) @(posedge clk);
    #1;
    check("next_wb_idx", wb_rd_idx, 9);
    check("next_wb_data", wb_rd_data, 64'h1F);
    retire();
    check("next_ms", mscratch, 64'h77);
    set_inst(3'b001, 12'h340, 5'd1, 64'hBAD, 5'd1);
    inst_valid = 1;
    @(posedge clk); #1;
    inst_valid = 0;
    @(posedge clk); #1;
    check("pre_rst_wr", csr_wr_ena, 1);
    rst = 1;
    #1;
    check("arst_wr_ena", csr_wr_ena, 0);
    check("arst_wr_data", csr_wr_data, 0);
    check("arst_idx", csr_idx, 0);
    check("arst_ready", inst_ready, 0);
    check("arst_valid", wb_valid, 0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    check("arst_ms", mscratch, 64'h77);
    check("arst_release", inst_ready, 1);
    issue(3'b010, 12'h340, 5'd0, 64'h0, 5'd4);
    check("arst_after_idx", wb_rd_idx, 4);
    check("arst_after_data", wb_rd_data, 64'h77);
    retire();
    check("never_both", both_high, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/csr_exu.md
# csr_exu

CSR instruction execution unit sitting directly upstream of the machine-mode CSR register file. It accepts one decoded Zicsr instruction at a time and performs the read-modify-write sequence against the CSR file's read/write port. It returns the old CSR value to integer writeback through a valid/ready handshake. It also flags illegal CSR accesses, so the core never writes the read-only CSR space.

## Interface
Parameters:
- XLEN, 64, data width; must match `REG_BUS`.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- inst_valid  in  1  decoded CSR instruction present.
- inst_ready  out  1  unit can accept an instruction.
- funct3  in  3  Zicsr funct3.
- inst_csr_idx  in  12  CSR address field.
- rs1_idx  in  5  rs1 field; doubles as the uimm field for the immediate forms.
- rs1_data  in  XLEN  rs1 register value.
- rd_idx  in  5  destination register.
- csr_rd_ena  out  1  CSR file read enable.
- csr_wr_ena  out  1  CSR file write enable.
- csr_idx  out  12  CSR file address.
- csr_wr_data  out  XLEN  CSR file write data.
- csr_rd_data  in  XLEN  CSR file read data; combinational from csr_idx/csr_rd_ena.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback accepts the result.
- wb_rd_ena  out  1  write rd.
- wb_rd_idx  out  5  rd index.
- wb_rd_data  out  XLEN  old CSR value.
- wb_illegal  out  1  illegal-instruction indication; qualified by wb_valid.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- Reset (asynchronous) sets the FSM to IDLE, clears all latched fields, and clears every output to 0.
- inst_ready = (state==IDLE) & ~rst.

IDLE:
- On inst_valid & inst_ready, latch funct3, inst_csr_idx, rs1_idx, rs1_data, and rd_idx.
- The source operand src is computed at latch time:
  - funct3[2]=0: src = rs1_data.
  - funct3[2]=1: src = zero-extended rs1_idx.
- Go to READ.

Decode of the latched funct3:
- 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- 000 and 100 are illegal.

Derived flags:
- do_write = RW/RWI, or (RS/RC/RSI/RCI with rs1_idx!=0).
- do_read = not (RW/RWI with rd_idx==0).
- illegal = illegal funct3, or (do_write & csr_idx[11:10]==2'b11).

READ (1 cycle):
- Drive csr_idx = latched index and csr_rd_ena = do_read & ~illegal.
- Capture csr_rd_data into old_val on the clock edge; old_val = 0 when no read is performed.
- Go to WRITE.

WRITE (1 cycle):
- csr_wr_ena = do_write & ~illegal.
- csr_wr_data depends on the operation:
  - RW/RWI: src.
  - RS/RSI: old_val | src.
  - RC/RCI: old_val & ~src.
- Go to RESP.

RESP:
- Hold wb_valid=1, wb_rd_idx, wb_rd_data=old_val, and wb_illegal=illegal.
- wb_rd_ena = ~illegal & (rd_idx!=0).
- On wb_ready, go to IDLE and clear wb_valid.

Output and arithmetic rules:
- csr_rd_ena and csr_wr_ena are never both high in the same cycle.
- csr_idx is 0 outside READ/WRITE.
- All arithmetic is full XLEN, bitwise; there is no carry.
- A read of an unimplemented CSR returns 0 from the CSR file and is not flagged illegal.

## Timing
- Handshake at edge T, READ in cycle T+1, WRITE in cycle T+2, wb_valid first high in cycle T+3.
- Minimum issue interval is 4 cycles when wb_ready is held high.
- old_val reflects the CSR contents in the READ cycle. mcycle therefore returns its value in cycle T+1, and a CSRRW to mcycle in WRITE makes mcycle read back the written value on the following cycle.
- wb_valid stays high, with all wb_* outputs stable, until wb_ready is sampled high. A new instruction is accepted no earlier than the cycle after the RESP handshake.
- inst_valid is ignored outside IDLE, and latched fields do not change.
- rst asserted in any state forces IDLE immediately, de-asserts csr_wr_ena with no partial write, and drops wb_valid. The interrupted instruction is lost.
- Illegal instructions still traverse READ/WRITE with both enables low and keep the same latency.

## Test plan
- Reset then CSRRS x5, misa(0x301), rs1=x0: no write; wb_valid at T+3; wb_rd_idx=5; wb_rd_data=0x8000000000000100; wb_illegal=0.
- CSRRW x0, mcycle(0xB00), rs1_data=0x100: csr_rd_ena low in READ; write 0x100 in WRITE; the next read of mcycle returns 0x101 or later; wb_rd_ena=0.
- CSRRSI then CSRRCI on mcycle with uimm=0x5, each with rd=x1:
  - Set: csr_wr_data = old|0x5.
  - Clear: csr_wr_data = old&~0x5.
  - wb_rd_data equals the value captured in READ each time.
- CSRRW x3, mhartid(0xF14): wb_illegal=1, wb_rd_ena=0, csr_wr_ena never high. Repeat with funct3=100: illegal, no CSR access.
- Hold wb_ready=0 for 5 cycles in RESP with inst_valid=1:
  - wb_* outputs remain stable and inst_ready stays 0.
  - Release wb_ready; the next instruction is accepted the following cycle.
- Assert rst during WRITE: all outputs read 0 immediately and no CSR is modified. After release, inst_ready=1 and a new instruction completes normally.
